// File: rtl/rotate_commit_pkg.sv
// Shared types for the rotation arbiter: piece colors and orientations.
package rotate_commit_pkg;

    typedef enum logic [2:0] {
        YELLOW = 3'd0,
        CYAN   = 3'd1,
        PURPLE = 3'd2,
        GREEN  = 3'd3,
        RED    = 3'd4,
        BLUE   = 3'd5,
        ORANGE = 3'd6
    } block_color;

    // Stepping left adds one, stepping right subtracts one (mod 4).
    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        ROT_LEFT  = 2'd1,
        ROT2      = 2'd2,
        ROT_RIGHT = 2'd3
    } orientation;

endpackage

// File: rtl/rotate_commit_if.sv
// Bundle of game-controller, rotation-calculator and board-read signals
// around the rotation arbiter. The slave side is the arbiter itself.
interface rotate_commit_if;
    import rotate_commit_pkg::*;

    logic        spawn;
    block_color  spawn_color;
    logic [19:0] spawn_x;
    logic [19:0] spawn_y;
    logic        rot_req;
    logic        rot_left;
    logic [19:0] cand_x;
    logic [19:0] cand_y;
    logic        rd_en;
    logic [4:0]  rd_x;
    logic [4:0]  rd_y;
    logic        rd_occupied;
    logic        piece_valid;
    block_color  piece_color;
    logic [19:0] piece_x;
    logic [19:0] piece_y;
    orientation  cur_orientation;
    logic        busy;
    logic        done;
    logic        accepted;

    modport master (
        output spawn, spawn_color, spawn_x, spawn_y,
        output rot_req, rot_left, cand_x, cand_y,
        output rd_occupied,
        input  rd_en, rd_x, rd_y,
        input  piece_valid, piece_color, piece_x, piece_y, cur_orientation,
        input  busy, done, accepted
    );

    modport slave (
        input  spawn, spawn_color, spawn_x, spawn_y,
        input  rot_req, rot_left, cand_x, cand_y,
        input  rd_occupied,
        output rd_en, rd_x, rd_y,
        output piece_valid, piece_color, piece_x, piece_y, cur_orientation,
        output busy, done, accepted
    );

endinterface

// File: rtl/rotate_commit.sv
// Rotation arbiter for the active tetromino. Owns the committed piece,
// bounds-checks a latched rotation candidate, probes the board RAM one
// cell per cycle and commits or rejects the candidate.
module rotate_commit
    import rotate_commit_pkg::*;
#(
    parameter int X_MAX = 10,
    parameter int Y_MAX = 20
) (
    input  logic          clk,
    input  logic          reset,
    rotate_commit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNDS = 2'd1,
        PROBE  = 2'd2,
        LAST   = 2'd3
    } state_t;

    localparam logic [4:0] X_LIM = 5'(X_MAX);
    localparam logic [4:0] Y_LIM = 5'(Y_MAX);

    state_t      state, state_n;
    logic [2:0]  idx, idx_n;
    logic [19:0] cand_x_q, cand_x_n;
    logic [19:0] cand_y_q, cand_y_n;
    logic        left_q, left_n;
    logic        fail, fail_n;
    logic        rd_pend, rd_pend_n;
    logic        rd_en_q, rd_en_n;
    logic [4:0]  rd_x_q, rd_x_n;
    logic [4:0]  rd_y_q, rd_y_n;
    logic        valid_q, valid_n;
    block_color  color_q, color_n;
    logic [19:0] px_q, px_n;
    logic [19:0] py_q, py_n;
    orientation  orient_q, orient_n;
    logic        busy_q, busy_n;
    logic        done_q, done_n;
    logic        acc_q, acc_n;

    logic        oob;
    logic        fail_final;
    orientation  orient_step;

    // Pick packed cell k out of a 4-cell coordinate word.
    function automatic logic [4:0] cell_sel(input logic [19:0] v, input logic [1:0] k);
        case (k)
            2'd0:    cell_sel = v[4:0];
            2'd1:    cell_sel = v[9:5];
            2'd2:    cell_sel = v[14:10];
            default: cell_sel = v[19:15];
        endcase
    endfunction

    // Flag any latched candidate cell outside the board; unsigned underflow lands here too.
    always_comb begin
        oob = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (cand_x_q[5*k +: 5] >= X_LIM || cand_y_q[5*k +: 5] >= Y_LIM) begin
                oob = 1'b1;
            end
        end
    end

    // Orientation the piece would take if the pending rotation commits.
    always_comb begin
        orient_step = left_q ? orientation'(orient_q + 2'd1) : orientation'(orient_q - 2'd1);
        fail_final  = fail | (rd_pend & bus.rd_occupied);
    end

    // Next-state and next-output logic; spawn overrides any in-progress check.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        cand_x_n  = cand_x_q;
        cand_y_n  = cand_y_q;
        left_n    = left_q;
        fail_n    = fail;
        rd_pend_n = rd_en_q;
        rd_en_n   = 1'b0;
        rd_x_n    = rd_x_q;
        rd_y_n    = rd_y_q;
        valid_n   = valid_q;
        color_n   = color_q;
        px_n      = px_q;
        py_n      = py_q;
        orient_n  = orient_q;
        busy_n    = busy_q;
        done_n    = 1'b0;
        acc_n     = acc_q;

        case (state)
            IDLE: begin
                if (bus.rot_req && valid_q) begin
                    cand_x_n = bus.cand_x;
                    cand_y_n = bus.cand_y;
                    left_n   = bus.rot_left;
                    fail_n   = 1'b0;
                    busy_n   = 1'b1;
                    state_n  = BOUNDS;
                end
            end
            BOUNDS: begin
                if (oob) begin
                    done_n  = 1'b1;
                    acc_n   = 1'b0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    rd_en_n = 1'b1;
                    rd_x_n  = cell_sel(cand_x_q, 2'd0);
                    rd_y_n  = cell_sel(cand_y_q, 2'd0);
                    idx_n   = 3'd1;
                    state_n = PROBE;
                end
            end
            PROBE: begin
                if (rd_pend && bus.rd_occupied) begin
                    fail_n = 1'b1;
                end
                if (idx != 3'd4) begin
                    rd_en_n = 1'b1;
                    rd_x_n  = cell_sel(cand_x_q, idx[1:0]);
                    rd_y_n  = cell_sel(cand_y_q, idx[1:0]);
                    idx_n   = idx + 3'd1;
                end else begin
                    state_n = LAST;
                end
            end
            LAST: begin
                fail_n = fail_final;
                if (!fail_final) begin
                    px_n     = cand_x_q;
                    py_n     = cand_y_q;
                    orient_n = orient_step;
                end
                done_n  = 1'b1;
                acc_n   = !fail_final;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (bus.spawn) begin
            color_n   = bus.spawn_color;
            px_n      = bus.spawn_x;
            py_n      = bus.spawn_y;
            orient_n  = NORMAL;
            valid_n   = 1'b1;
            state_n   = IDLE;
            busy_n    = 1'b0;
            done_n    = 1'b0;
            rd_en_n   = 1'b0;
            rd_pend_n = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= 3'd0;
            cand_x_q <= 20'd0;
            cand_y_q <= 20'd0;
            left_q   <= 1'b0;
            fail     <= 1'b0;
            rd_pend  <= 1'b0;
            rd_en_q  <= 1'b0;
            rd_x_q   <= 5'd0;
            rd_y_q   <= 5'd0;
            valid_q  <= 1'b0;
            color_q  <= YELLOW;
            px_q     <= 20'd0;
            py_q     <= 20'd0;
            orient_q <= NORMAL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            cand_x_q <= cand_x_n;
            cand_y_q <= cand_y_n;
            left_q   <= left_n;
            fail     <= fail_n;
            rd_pend  <= rd_pend_n;
            rd_en_q  <= rd_en_n;
            rd_x_q   <= rd_x_n;
            rd_y_q   <= rd_y_n;
            valid_q  <= valid_n;
            color_q  <= color_n;
            px_q     <= px_n;
            py_q     <= py_n;
            orient_q <= orient_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            acc_q    <= acc_n;
        end
    end

    assign bus.rd_en           = rd_en_q;
    assign bus.rd_x            = rd_x_q;
    assign bus.rd_y            = rd_y_q;
    assign bus.piece_valid     = valid_q;
    assign bus.piece_color     = color_q;
    assign bus.piece_x         = px_q;
    assign bus.piece_y         = py_q;
    assign bus.cur_orientation = orient_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.accepted        = acc_q;

endmodule
